// File: rtl/hack_arb_pkg.sv
// Shared types and constants for the two-requester Hack data-memory arbiter.
package hack_arb_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

endpackage

// File: rtl/mux_2x1_16bits.sv
// 16-bit two-input multiplexer: y = sel ? b : a.
module mux_2x1_16bits
    import hack_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/hack_mem_arbiter_2x1.sv
// Round-robin arbiter with bounded-hold preemption sharing one Hack memory port.
// Define HACK_ARB_FIXED_PRIORITY_EN to make A the fixed high-priority requester.
module hack_mem_arbiter_2x1
    import hack_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_a_in,
    input  logic [DATA_W-1:0] addr_a_in,
    input  logic [DATA_W-1:0] data_a_in,
    input  logic              we_a_in,
    input  logic              req_b_in,
    input  logic [DATA_W-1:0] addr_b_in,
    input  logic [DATA_W-1:0] data_b_in,
    input  logic              we_b_in,
    output logic              gnt_a_out,
    output logic              gnt_b_out,
    output logic [DATA_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_we_out
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_next;
    owner_t           last_owner;
    logic             sel;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= OWNER_B;
        end else begin
            state    <= state_next;
            hold_cnt <= cnt_next;
            if (state_next == OWN_A) begin
                last_owner <= OWNER_A;
            end else if (state_next == OWN_B) begin
                last_owner <= OWNER_B;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            IDLE: begin
`ifdef HACK_ARB_FIXED_PRIORITY_EN
                if (req_a_in) begin
                    state_next = OWN_A;
                end else if (req_b_in) begin
                    state_next = OWN_B;
                end
`else
                if (req_a_in && (!req_b_in || last_owner == OWNER_B)) begin
                    state_next = OWN_A;
                end else if (req_b_in) begin
                    state_next = OWN_B;
                end
`endif
            end
            OWN_A: begin
                if (!req_a_in) begin
                    state_next = req_b_in ? OWN_B : IDLE;
                end else if (req_b_in) begin
`ifndef HACK_ARB_FIXED_PRIORITY_EN
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = OWN_B;
                    end else begin
                        cnt_next = hold_cnt + 1'b1;
                    end
`endif
                end
            end
            OWN_B: begin
                if (!req_b_in) begin
                    state_next = req_a_in ? OWN_A : IDLE;
                end else if (req_a_in) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = OWN_A;
                    end else begin
                        cnt_next = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grants and write enable decode from the registered state only.
    always_comb begin
        gnt_a_out  = (state == OWN_A);
        gnt_b_out  = (state == OWN_B);
        sel        = (state == OWN_B);
        mem_we_out = (gnt_a_out & we_a_in) | (gnt_b_out & we_b_in);
    end

    mux_2x1_16bits u_addr_mux (
        .a   (addr_a_in),
        .b   (addr_b_in),
        .sel (sel),
        .y   (mem_addr_out)
    );

    mux_2x1_16bits u_data_mux (
        .a   (data_a_in),
        .b   (data_b_in),
        .sel (sel),
        .y   (mem_data_out)
    );

endmodule

// File: tb/tb_hack_mem_arbiter_2x1.sv
// Self-checking bench for hack_mem_arbiter_2x1: directed scenarios plus random traffic
// compared against an ownership model built from the arbitration rules.
module tb_hack_mem_arbiter_2x1;

    localparam int MAX_HOLD = 4;
    localparam int M_NONE = 0;
    localparam int M_A    = 1;
    localparam int M_B    = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_a_in, req_b_in, we_a_in, we_b_in;
    logic [15:0] addr_a_in, data_a_in, addr_b_in, data_b_in;
    logic        gnt_a_out, gnt_b_out, mem_we_out;
    logic [15:0] mem_addr_out, mem_data_out;

    int checks   = 0;
    int failures = 0;

    int m_owner     = M_NONE;
    int m_last      = M_B;
    int m_contested = 0;

    always #5 clk_in = ~clk_in;

    hack_mem_arbiter_2x1 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .req_a_in     (req_a_in),
        .addr_a_in    (addr_a_in),
        .data_a_in    (data_a_in),
        .we_a_in      (we_a_in),
        .req_b_in     (req_b_in),
        .addr_b_in    (addr_b_in),
        .data_b_in    (data_b_in),
        .we_b_in      (we_b_in),
        .gnt_a_out    (gnt_a_out),
        .gnt_b_out    (gnt_b_out),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_we_out   (mem_we_out)
    );

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Ownership model: who holds the port, who held it last, and how many
    // consecutive edges the current owner has kept it while the other waited.
    task automatic model_update();
        int  nxt;
        logic other_waiting;
        logic can_preempt;
        nxt = m_owner;
        if (rst_in) begin
            m_owner     = M_NONE;
            m_last      = M_B;
            m_contested = 0;
            return;
        end
        other_waiting = (m_owner == M_A) ? req_b_in : req_a_in;
`ifdef HACK_ARB_FIXED_PRIORITY_EN
        can_preempt = (m_owner == M_B);
`else
        can_preempt = 1'b1;
`endif
        if (m_owner == M_NONE) begin
            if (req_a_in && req_b_in) begin
`ifdef HACK_ARB_FIXED_PRIORITY_EN
                nxt = M_A;
`else
                nxt = (m_last == M_A) ? M_B : M_A;
`endif
            end else if (req_a_in) begin
                nxt = M_A;
            end else if (req_b_in) begin
                nxt = M_B;
            end
        end else begin
            logic own_req;
            own_req = (m_owner == M_A) ? req_a_in : req_b_in;
            if (!own_req) begin
                nxt = other_waiting ? (M_A + M_B - m_owner) : M_NONE;
            end else if (other_waiting && can_preempt && (m_contested + 1 == MAX_HOLD)) begin
                nxt = M_A + M_B - m_owner;
            end
        end
        if (nxt == m_owner && nxt != M_NONE && other_waiting && can_preempt) begin
            m_contested = m_contested + 1;
        end else begin
            m_contested = 0;
        end
        if (nxt != M_NONE) begin
            m_last = nxt;
        end
        m_owner = nxt;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_addr, exp_data;
        logic        exp_we;
        exp_addr = (m_owner == M_B) ? addr_b_in : addr_a_in;
        exp_data = (m_owner == M_B) ? data_b_in : data_a_in;
        exp_we   = (m_owner == M_A) ? we_a_in : ((m_owner == M_B) ? we_b_in : 1'b0);
        chk({tag, ".gnt_a"}, 16'(gnt_a_out), 16'(m_owner == M_A));
        chk({tag, ".gnt_b"}, 16'(gnt_b_out), 16'(m_owner == M_B));
        chk({tag, ".addr"}, mem_addr_out, exp_addr);
        chk({tag, ".data"}, mem_data_out, exp_data);
        chk({tag, ".we"}, 16'(mem_we_out), 16'(exp_we));
        chk({tag, ".excl"}, 16'(gnt_a_out & gnt_b_out), 16'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in   = 1'b1;
        req_a_in = 1'b0;  req_b_in = 1'b0;
        we_a_in  = 1'b1;  we_b_in  = 1'b1;
        addr_a_in = 16'h1234;  data_a_in = 16'h5678;
        addr_b_in = 16'hABCD;  data_b_in = 16'hEF01;

        // Reset state
        tick();
        tick();
        chk("rst.gnt_a", 16'(gnt_a_out), 16'd0);
        chk("rst.gnt_b", 16'(gnt_b_out), 16'd0);
        chk("rst.we", 16'(mem_we_out), 16'd0);
        chk("rst.addr", mem_addr_out, 16'h1234);
        chk("rst.data", mem_data_out, 16'h5678);
        chk("rst.hold", 16'(dut.hold_cnt), 16'd0);

        // A alone: grant after one edge, shared port follows A
        rst_in = 1'b0;
        req_a_in = 1'b1;  addr_a_in = 16'h0010;  we_a_in = 1'b1;
        we_b_in = 1'b1;
        chk("a_only.pre_gnt", 16'(gnt_a_out), 16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("a_only.gnt_a", 16'(gnt_a_out), 16'd1);
            chk("a_only.gnt_b", 16'(gnt_b_out), 16'd0);
            chk("a_only.addr", mem_addr_out, 16'h0010);
            chk("a_only.we", 16'(mem_we_out), 16'd1);
            check_all("a_only");
        end

        // Simultaneous requests: A first, then direct hand-off to B
        req_a_in = 1'b0;
        do_reset();
        req_a_in = 1'b1;  req_b_in = 1'b1;
        tick();
        chk("tie.first_a", 16'(gnt_a_out), 16'd1);
        tick();
        chk("tie.second_a", 16'(gnt_a_out), 16'd1);
        req_a_in = 1'b0;
        tick();
        chk("tie.handoff_b", 16'(gnt_b_out), 16'd1);
        chk("tie.handoff_a", 16'(gnt_a_out), 16'd0);
        check_all("tie");

`ifndef HACK_ARB_FIXED_PRIORITY_EN
        // Continuous contention: blocks of MAX_HOLD cycles, A first
        req_a_in = 1'b0;  req_b_in = 1'b0;
        do_reset();
        req_a_in = 1'b1;  req_b_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            we_a_in = 1'($urandom);
            we_b_in = 1'($urandom);
            tick();
            chk("fair.gnt_a", 16'(gnt_a_out), 16'(((i / MAX_HOLD) % 2) == 0));
            chk("fair.gnt_b", 16'(gnt_b_out), 16'(((i / MAX_HOLD) % 2) == 1));
            check_all("fair");
        end
`endif

        // B alone for 50 cycles: never preempted, counter stays cleared
        req_a_in = 1'b0;  req_b_in = 1'b0;
        do_reset();
        req_b_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            addr_b_in = 16'($urandom);
            data_b_in = 16'($urandom);
            we_b_in   = 1'($urandom);
            tick();
            chk("b_alone.gnt_b", 16'(gnt_b_out), 16'd1);
            chk("b_alone.hold", 16'(dut.hold_cnt), 16'd0);
            check_all("b_alone");
        end

`ifndef HACK_ARB_FIXED_PRIORITY_EN
        // Reset while B owns the port under contention
        req_b_in = 1'b0;
        do_reset();
        req_a_in = 1'b1;  req_b_in = 1'b1;  we_b_in = 1'b1;  we_a_in = 1'b1;
        for (int i = 0; i < MAX_HOLD + 1; i++) begin
            tick();
        end
        chk("rst_mid.pre_b", 16'(gnt_b_out), 16'd1);
        rst_in = 1'b1;
        tick();
        chk("rst_mid.gnt_a", 16'(gnt_a_out), 16'd0);
        chk("rst_mid.gnt_b", 16'(gnt_b_out), 16'd0);
        chk("rst_mid.we", 16'(mem_we_out), 16'd0);
        rst_in = 1'b0;
        tick();
        chk("rst_mid.tie_a", 16'(gnt_a_out), 16'd1);
        check_all("rst_mid");
`else
        // Fixed priority: A keeps the port under contention until it lets go
        req_b_in = 1'b0;
        do_reset();
        req_a_in = 1'b1;  req_b_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("fixed.gnt_a", 16'(gnt_a_out), 16'd1);
            check_all("fixed");
        end
        req_a_in = 1'b0;
        tick();
        chk("fixed.gnt_b", 16'(gnt_b_out), 16'd1);
        check_all("fixed");
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_in    = ($urandom_range(63) == 0);
            req_a_in  = ($urandom_range(3) != 0);
            req_b_in  = ($urandom_range(3) != 0);
            we_a_in   = 1'($urandom);
            we_b_in   = 1'($urandom);
            addr_a_in = 16'($urandom);
            data_a_in = 16'($urandom);
            addr_b_in = 16'($urandom);
            data_b_in = 16'($urandom);
            tick();
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
